// File: rtl/fpga_exit_status_pkg.sv
// Shared types and constants for the FPGA exit-status reporter.
// The report bytes are only used when EXIT_UART_REPORT_EN is defined.
package fpga_exit_status_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PASS,
    ST_BLINK_ON,
    ST_BLINK_OFF,
    ST_GAP
  } state_e;

  localparam int unsigned REPORT_LEN = 12;

  localparam logic [7:0] ASCII_X  = 8'h58;
  localparam logic [7:0] ASCII_EQ = 8'h3D;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    logic [7:0] res;
    res = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    return res;
  endfunction

  // Report line layout: "X=" + 8 hex digits (MSB first) + CR LF.
  function automatic logic [7:0] report_byte(input logic [3:0] idx, input logic [31:0] code);
    logic [3:0] nib;
    logic [7:0] res;
    nib = 4'h0;
    case (idx)
      4'd2:    nib = code[31:28];
      4'd3:    nib = code[27:24];
      4'd4:    nib = code[23:20];
      4'd5:    nib = code[19:16];
      4'd6:    nib = code[15:12];
      4'd7:    nib = code[11:8];
      4'd8:    nib = code[7:4];
      4'd9:    nib = code[3:0];
      default: nib = 4'h0;
    endcase
    case (idx)
      4'd0:    res = ASCII_X;
      4'd1:    res = ASCII_EQ;
      4'd10:   res = ASCII_CR;
      4'd11:   res = ASCII_LF;
      default: res = hex_ascii(nib);
    endcase
    return res;
  endfunction

endpackage

// File: rtl/exit_uart_tx.sv
// 8N1 UART serialiser with valid/ready byte input; ready is also raised in the
// final stop-bit cycle so consecutive bytes go out back-to-back.
module exit_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk_gen,
  input  logic       rst_n,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_RELOAD = CW'(CLKS_PER_BIT - 1);

  logic [9:0]    shift_q, shift_d;
  logic          busy_q, busy_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic          bit_tick;
  logic          last_bit;

  assign bit_tick = busy_q && (clk_cnt_q == '0);
  assign last_bit = bit_tick && (bit_cnt_q == 4'd9);
  assign ready_o  = ~busy_q | last_bit;
  assign tx_o     = shift_q[0];

  always_comb begin
    shift_d   = shift_q;
    busy_d    = busy_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    if (valid_i && ready_o) begin
      shift_d   = {1'b1, data_i, 1'b0};
      busy_d    = 1'b1;
      clk_cnt_d = CNT_RELOAD;
      bit_cnt_d = 4'd0;
    end else if (busy_q) begin
      if (bit_tick) begin
        // Shifting ones in leaves the line idle high after the stop bit.
        shift_d   = {1'b1, shift_q[9:1]};
        clk_cnt_d = CNT_RELOAD;
        if (last_bit) busy_d = 1'b0;
        else          bit_cnt_d = bit_cnt_q + 4'd1;
      end else begin
        clk_cnt_d = clk_cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '1;
      busy_q    <= 1'b0;
      clk_cnt_q <= '0;
      bit_cnt_q <= 4'd0;
    end else begin
      shift_q   <= shift_d;
      busy_q    <= busy_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/fpga_exit_status_reporter.sv
// Captures the first SoC exit code and reports it on LEDs (steady = pass, blink count = code[3:0]).
// EXIT_UART_REPORT_EN adds a serial "X=<hex>\r\n" report; without it uart_tx_o is tied high.
//
// state        | meaning
// ST_IDLE      | armed, waiting for a capture edge
// ST_PASS      | code 0 captured, LED steady on
// ST_BLINK_ON  | LED on-phase of one pulse
// ST_BLINK_OFF | LED off-phase of one pulse
// ST_GAP       | LED off between bursts
module fpga_exit_status_reporter
  import fpga_exit_status_pkg::*;
#(
  parameter int unsigned BLINK_HALF_CYCLES = 5000000,
  parameter int unsigned GAP_CYCLES        = 20000000,
  parameter int unsigned UART_CLKS_PER_BIT = 434
) (
  input  logic        clk_gen,
  input  logic        rst_n,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  input  logic        clear_i,
  output logic        done_led_o,
  output logic        pass_o,
  output logic        code_led_o,
  output logic        uart_tx_o
);

  localparam int unsigned TMR_MAX = (GAP_CYCLES > BLINK_HALF_CYCLES) ? GAP_CYCLES : BLINK_HALF_CYCLES;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] HALF_LOAD = TMR_W'(BLINK_HALF_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(GAP_CYCLES - 1);

  if (BLINK_HALF_CYCLES == 0 || GAP_CYCLES == 0 || UART_CLKS_PER_BIT == 0) begin : g_bad_param
    $error("fpga_exit_status_reporter: cycle parameters must be nonzero");
  end

  state_e           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [3:0]       pulse_q, pulse_d;
  logic [31:0]      code_q, code_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             led_q, led_d;
  logic             sync1_q, sync2_q, sync3_q;
  logic             valid_edge;
  logic             capture;

  assign valid_edge = sync2_q & ~sync3_q;
  // First exit wins; a coincident clear discards the edge.
  assign capture    = valid_edge & ~done_q & ~clear_i;

  always_comb begin
    state_d = state_q;
    tmr_d   = (tmr_q == '0) ? tmr_q : tmr_q - TMR_W'(1);
    pulse_d = pulse_q;
    code_d  = code_q;
    done_d  = done_q;
    pass_d  = pass_q;
    if (clear_i) begin
      state_d = ST_IDLE;
      tmr_d   = '0;
      pulse_d = 4'd0;
      code_d  = 32'd0;
      done_d  = 1'b0;
      pass_d  = 1'b0;
    end else begin
      if (capture) begin
        code_d = exit_value_i;
        done_d = 1'b1;
        pass_d = (exit_value_i == 32'd0);
      end
      case (state_q)
        ST_IDLE: begin
          if (capture) begin
            state_d = (exit_value_i == 32'd0) ? ST_PASS : ST_BLINK_ON;
            tmr_d   = HALF_LOAD;
            pulse_d = 4'd0;
          end
        end
        ST_PASS: state_d = ST_PASS;
        ST_BLINK_ON: begin
          if (tmr_q == '0) begin
            state_d = ST_BLINK_OFF;
            tmr_d   = HALF_LOAD;
          end
        end
        ST_BLINK_OFF: begin
          if (tmr_q == '0) begin
            // Nibble 0 minus one wraps to 15, giving 16 pulses.
            if (pulse_q == (code_q[3:0] - 4'd1)) begin
              state_d = ST_GAP;
              tmr_d   = GAP_LOAD;
              pulse_d = 4'd0;
            end else begin
              state_d = ST_BLINK_ON;
              tmr_d   = HALF_LOAD;
              pulse_d = pulse_q + 4'd1;
            end
          end
        end
        ST_GAP: begin
          if (tmr_q == '0) begin
            state_d = ST_BLINK_ON;
            tmr_d   = HALF_LOAD;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    led_d = (state_d == ST_PASS) || (state_d == ST_BLINK_ON);
  end

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      pulse_q <= 4'd0;
      code_q  <= 32'd0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      led_q   <= 1'b0;
    end else begin
      sync1_q <= exit_valid_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      state_q <= state_d;
      tmr_q   <= tmr_d;
      pulse_q <= pulse_d;
      code_q  <= code_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      led_q   <= led_d;
    end
  end

  assign done_led_o = done_q;
  assign pass_o     = pass_q;
  assign code_led_o = led_q;

`ifdef EXIT_UART_REPORT_EN
  logic       rep_active_q, rep_active_d;
  logic [3:0] rep_idx_q, rep_idx_d;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_byte;

  assign tx_valid = rep_active_q & ~clear_i;
  assign tx_byte  = report_byte(rep_idx_q, code_q);

  always_comb begin
    rep_active_d = rep_active_q;
    rep_idx_d    = rep_idx_q;
    if (clear_i) begin
      rep_active_d = 1'b0;
    end else if (capture) begin
      rep_active_d = 1'b1;
      rep_idx_d    = 4'd0;
    end else if (tx_valid && tx_ready) begin
      if (rep_idx_q == 4'(REPORT_LEN - 1)) rep_active_d = 1'b0;
      else                                 rep_idx_d    = rep_idx_q + 4'd1;
    end
  end

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      rep_active_q <= 1'b0;
      rep_idx_q    <= 4'd0;
    end else begin
      rep_active_q <= rep_active_d;
      rep_idx_q    <= rep_idx_d;
    end
  end

  exit_uart_tx #(
    .CLKS_PER_BIT(UART_CLKS_PER_BIT)
  ) u_uart_tx (
    .clk_gen (clk_gen),
    .rst_n   (rst_n),
    .data_i  (tx_byte),
    .valid_i (tx_valid),
    .ready_o (tx_ready),
    .tx_o    (uart_tx_o)
  );
`else
  assign uart_tx_o = 1'b1;
`endif

endmodule

// File: tb/tb_fpga_exit_status_reporter.sv
// Directed bench for fpga_exit_status_reporter with short blink/UART timings.
// UART report checks are built only when EXIT_UART_REPORT_EN is defined.
module tb_fpga_exit_status_reporter;

  logic        clk_gen = 1'b0;
  logic        rst_n;
  logic        exit_valid_i;
  logic [31:0] exit_value_i;
  logic        clear_i;
  logic        done_led_o;
  logic        pass_o;
  logic        code_led_o;
  logic        uart_tx_o;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk_gen = ~clk_gen;

  fpga_exit_status_reporter #(
    .BLINK_HALF_CYCLES (4),
    .GAP_CYCLES        (8),
    .UART_CLKS_PER_BIT (4)
  ) dut (
    .clk_gen      (clk_gen),
    .rst_n        (rst_n),
    .exit_valid_i (exit_valid_i),
    .exit_value_i (exit_value_i),
    .clear_i      (clear_i),
    .done_led_o   (done_led_o),
    .pass_o       (pass_o),
    .code_led_o   (code_led_o),
    .uart_tx_o    (uart_tx_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_gen);
    #1;
    cyc++;
  endtask

  task automatic clear_pulse();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  // Clear, drop exit_valid and let the synchroniser drain so the next rise is a fresh edge.
  task automatic rearm();
    clear_pulse();
    exit_valid_i = 1'b0;
    repeat (4) tick();
  endtask

  // Compare code_led_o against N x (4 on, 4 off) then 8 off, starting at burst start.
  task automatic blink_wave(input int n, input int samples, input int inj, output int mism);
    int   period;
    int   p;
    logic e;
    mism   = 0;
    period = n * 8 + 8;
    for (int k = 0; k < samples; k++) begin
      p = k % period;
      e = (p < n * 8) && ((p % 8) < 4);
      if (code_led_o !== e) mism++;
      if (inj >= 0 && k == inj) exit_valid_i = 1'b0;
      if (inj >= 0 && k == inj + 10) begin
        exit_value_i = 32'h1;
        exit_valid_i = 1'b1;
      end
      tick();
    end
  endtask

`ifdef EXIT_UART_REPORT_EN
  logic [7:0] exp_dead [12] = '{8'h58, 8'h3D, 8'h44, 8'h45, 8'h41, 8'h44,
                                8'h42, 8'h45, 8'h45, 8'h46, 8'h0D, 8'h0A};
  logic [7:0] exp_1234 [12] = '{8'h58, 8'h3D, 8'h31, 8'h32, 8'h33, 8'h34,
                                8'h35, 8'h36, 8'h37, 8'h38, 8'h0D, 8'h0A};

  task automatic rx_wait_start(output int t);
    int n;
    n = 0;
    while (uart_tx_o !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    check("rx_start", 32'(uart_tx_o), 32'd0);
    t = cyc;
  endtask

  // 'at' is how many cycles into the start bit we already are.
  task automatic rx_finish(input int at, output logic [7:0] b);
    repeat (2 - at) tick();
    for (int i = 0; i < 8; i++) begin
      repeat (4) tick();
      b[i] = uart_tx_o;
    end
    repeat (4) tick();
    check("rx_stop", 32'(uart_tx_o), 32'd1);
  endtask

  task automatic rx_report(input logic [7:0] exp [12], input string tag);
    int         t;
    int         tp;
    logic [7:0] b;
    tp = 0;
    for (int i = 0; i < 12; i++) begin
      rx_wait_start(t);
      rx_finish(0, b);
      check({tag, "_byte"}, 32'(b), 32'(exp[i]));
      if (i > 0) check({tag, "_gap"}, 32'(t - tp), 32'd40);
      tp = t;
    end
  endtask
`endif

  initial begin
    int         m;
    int         zeros;
`ifdef EXIT_UART_REPORT_EN
    int         t;
    logic [7:0] b;
`endif
    rst_n        = 1'b0;
    exit_valid_i = 1'b0;
    exit_value_i = 32'd0;
    clear_i      = 1'b0;
    #1;
    check("rst_done", 32'(done_led_o), 32'd0);
    check("rst_pass", 32'(pass_o), 32'd0);
    check("rst_led", 32'(code_led_o), 32'd0);
    check("rst_tx", 32'(uart_tx_o), 32'd1);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Pass: code 0 -> steady LED.
    exit_value_i = 32'd0;
    exit_valid_i = 1'b1;
    repeat (2) tick();
    check("pass_done_early", 32'(done_led_o), 32'd0);
    tick();
    check("pass_done", 32'(done_led_o), 32'd1);
    check("pass_pass", 32'(pass_o), 32'd1);
    check("pass_led", 32'(code_led_o), 32'd1);
    zeros = 0;
    repeat (12) begin
      tick();
      if (code_led_o !== 1'b1) zeros++;
    end
    check("pass_led_hold", 32'(zeros), 32'd0);
    clear_pulse();
    check("clr_pass_done", 32'(done_led_o), 32'd0);
    check("clr_pass_pass", 32'(pass_o), 32'd0);
    check("clr_pass_led", 32'(code_led_o), 32'd0);
    exit_valid_i = 1'b0;
    repeat (4) tick();

    // Code 3: three pulses per burst.
    exit_value_i = 32'h3;
    exit_valid_i = 1'b1;
    repeat (3) tick();
    check("b3_done", 32'(done_led_o), 32'd1);
    check("b3_pass", 32'(pass_o), 32'd0);
    blink_wave(3, 64, -1, m);
    check("b3_wave", 32'(m), 32'd0);
    rearm();

    // Code 0x10: nibble 0 -> 16 pulses; later edge with 0x1 is ignored.
    exit_value_i = 32'h10;
    exit_valid_i = 1'b1;
    repeat (3) tick();
    blink_wave(16, 272, 20, m);
    check("b16_wave", 32'(m), 32'd0);
    check("b16_on_before_clr", 32'(code_led_o), 32'd1);
    clear_pulse();
    check("clr_on_done", 32'(done_led_o), 32'd0);
    check("clr_on_pass", 32'(pass_o), 32'd0);
    check("clr_on_led", 32'(code_led_o), 32'd0);
    zeros = 0;
    repeat (6) begin
      tick();
      if (code_led_o !== 1'b0) zeros++;
    end
    check("clr_idle_led", 32'(zeros), 32'd0);

    // Clear coincident with the capture edge: edge discarded.
    exit_valid_i = 1'b0;
    repeat (4) tick();
    exit_value_i = 32'h5;
    exit_valid_i = 1'b1;
    repeat (2) tick();
    clear_pulse();
    repeat (6) tick();
    check("coinc_done", 32'(done_led_o), 32'd0);
    check("coinc_led", 32'(code_led_o), 32'd0);
    exit_valid_i = 1'b0;
    repeat (4) tick();

`ifdef EXIT_UART_REPORT_EN
    exit_value_i = 32'hDEADBEEF;
    exit_valid_i = 1'b1;
    rx_report(exp_dead, "dead");
    rearm();

    // Reset in the middle of a frame, exit_valid held high.
    exit_value_i = 32'h12345678;
    exit_valid_i = 1'b1;
    repeat (2) begin
      rx_wait_start(t);
      rx_finish(0, b);
    end
    rx_wait_start(t);
    tick();
    check("pre_rst_tx", 32'(uart_tx_o), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_tx", 32'(uart_tx_o), 32'd1);
    check("rst_mid_done", 32'(done_led_o), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("recap_done", 32'(done_led_o), 32'd1);
    rx_report(exp_1234, "recap");

    // Clear during a report: current byte completes, then the line stays idle.
    rearm();
    exit_valid_i = 1'b1;
    repeat (3) begin
      rx_wait_start(t);
      rx_finish(0, b);
    end
    rx_wait_start(t);
    clear_pulse();
    rx_finish(1, b);
    check("clr_rep_byte", 32'(b), 32'h32);
    zeros = 0;
    repeat (100) begin
      tick();
      if (uart_tx_o !== 1'b1) zeros++;
    end
    check("clr_rep_idle", 32'(zeros), 32'd0);
`else
    // Reset mid-blink with exit_valid held high; recapture restarts the burst.
    exit_value_i = 32'h12345678;
    exit_valid_i = 1'b1;
    repeat (3) tick();
    repeat (2) tick();
    check("pre_rst_led", 32'(code_led_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_led", 32'(code_led_o), 32'd0);
    check("rst_mid_done", 32'(done_led_o), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("recap_done", 32'(done_led_o), 32'd1);
    blink_wave(8, 80, -1, m);
    check("recap_wave", 32'(m), 32'd0);
    check("uart_tied", 32'(uart_tx_o), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
